// File: rtl/obuf_drain_pkg.sv
// Shared constants, state encoding and helpers for the output-buffer drain controller.
//   OBD_ARRAYWIDTH : lanes per row (taken from `ARRAYWIDTH when the project config defines it)
//   OBD_DATASIZE   : bits per lane (taken from `OUTPUT_BUF_DATASIZE when defined)
//   OBD_ADDR_W     : output-buffer row address width (taken from `OBUF_ADDR_W when defined)
//   obd_state_t    : 2-bit drain FSM encoding
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif

`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif

`ifndef OBUF_ADDR_W
`define OBUF_ADDR_W 8
`endif

package obuf_drain_pkg;

    localparam int OBD_ARRAYWIDTH = `ARRAYWIDTH;
    localparam int OBD_DATASIZE   = `OUTPUT_BUF_DATASIZE;
    localparam int OBD_ADDR_W     = `OBUF_ADDR_W;

    typedef enum logic [1:0] {
        OBD_IDLE  = 2'd0,
        OBD_READ  = 2'd1,
        OBD_FLUSH = 2'd2,
        OBD_DONE  = 2'd3
    } obd_state_t;

    // A new read may launch only if, once this cycle's pop retires, the FIFO
    // plus the read already in flight leave room for its data two cycles out.
    function automatic logic read_slot_free(input logic [1:0] fifo_count,
                                            input logic       pop,
                                            input logic       inflight);
        int occ;
        occ = int'(fifo_count) - int'(pop) + int'(inflight);
        return occ <= 1;
    endfunction

endpackage

// File: rtl/obuf_drain_if.sv
// Bus bundle between the drain controller and its neighbours.
//   control : start, num_rows (in to drain), busy, done (out of drain)
//   buffer  : rd_en, rd_addr, clr_en, clr_addr (out), rd_data (in, 1-cycle latency)
//   stream  : out_valid, out_data (out), out_ready (in)
// Modport master is the drain controller; slave is the surrounding logic.
interface obuf_drain_if
    import obuf_drain_pkg::*;
#(
    parameter int ARRAYWIDTH = OBD_ARRAYWIDTH,
    parameter int DATASIZE   = OBD_DATASIZE,
    parameter int ADDR_W     = OBD_ADDR_W
);
    logic                           start;
    logic [ADDR_W-1:0]              num_rows;
    logic                           busy;
    logic                           done;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [ARRAYWIDTH*DATASIZE-1:0] rd_data;
    logic                           clr_en;
    logic [ADDR_W-1:0]              clr_addr;
    logic                           out_valid;
    logic                           out_ready;
    logic [ARRAYWIDTH*DATASIZE-1:0] out_data;

    modport master (
        input  start, num_rows, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, clr_en, clr_addr, out_valid, out_data
    );

    modport slave (
        output start, num_rows, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, clr_en, clr_addr, out_valid, out_data
    );
endinterface

// File: rtl/obuf_drain_fifo.sv
// Two-entry skid FIFO absorbing buffer read latency against downstream stalls.
//   clk, rst   : clock, synchronous active-low reset (empties the FIFO)
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : row to store
//   pop        : retire head this cycle (caller guarantees not empty)
//   count      : entries held, 0..2
//   head       : oldest entry, driven from storage registers only
module obuf_drain_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/obuf_drain.sv
// Drain controller: reads rows 0..num_rows-1 from the output buffer and streams
// them to the relu stage over valid/ready, one row per cycle when unstalled.
//   clk, rst : clock, synchronous active-low reset (aborts a drain, drops in-flight read)
//   bus      : obuf_drain_if.master (start/num_rows/busy/done, buffer read and clear
//              port, out_valid/out_ready/out_data stream)
// Build option DRAIN_CLEAR_EN: zero each row in the buffer one cycle after it is
// read; when undefined clr_en and clr_addr are held at 0.
//
// state     | meaning
// IDLE      | waiting for start
// READ      | issuing row reads while FIFO space allows
// FLUSH     | all reads issued, waiting for FIFO and in-flight read to empty
// DONE      | one-cycle done pulse, then back to IDLE
module obuf_drain
    import obuf_drain_pkg::*;
#(
    parameter int ARRAYWIDTH = OBD_ARRAYWIDTH,
    parameter int DATASIZE   = OBD_DATASIZE,
    parameter int ADDR_W     = OBD_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    obuf_drain_if.master  bus
);
    localparam int ROW_W = ARRAYWIDTH * DATASIZE;

    obd_state_t        state;
    obd_state_t        state_next;
    logic [ADDR_W-1:0] rows_q;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic [ROW_W-1:0]  fifo_head;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              fifo_drains;
    logic              busy;
    logic              done;

    assign pop        = (fifo_count != 2'd0) && bus.out_ready;
    assign issue      = (state == OBD_READ) && read_slot_free(fifo_count, pop, inflight);
    assign last_issue = issue && (addr_q == rows_q - ADDR_W'(1));
    // True when nothing will be left after this cycle, so done can follow the
    // final handshake directly.
    assign fifo_drains = !inflight && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    always_ff @(posedge clk) begin
        if (!rst) state <= OBD_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            // An empty drain passes through FLUSH, which finds nothing pending,
            // so busy spans two cycles before returning to IDLE.
            OBD_IDLE:  if (bus.start) state_next = (bus.num_rows == '0) ? OBD_FLUSH : OBD_READ;
            OBD_READ:  if (last_issue) state_next = OBD_FLUSH;
            OBD_FLUSH: if (fifo_drains) state_next = OBD_DONE;
            OBD_DONE:  state_next = OBD_IDLE;
            default:   state_next = OBD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != OBD_IDLE);
        done = (state == OBD_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rows_q   <= '0;
            addr_q   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == OBD_IDLE && bus.start) begin
                rows_q <= bus.num_rows;
                addr_q <= '0;
            end else if (issue && !last_issue) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    obuf_drain_fifo #(.WIDTH(ROW_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.rd_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

`ifdef DRAIN_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;

    always_ff @(posedge clk) begin
        if (!rst) clr_addr_q <= '0;
        else if (issue) clr_addr_q <= addr_q;
    end

    // inflight is exactly last cycle's rd_en and is dropped by reset, so a
    // read aborted by reset never produces a clear.
    assign bus.clr_en   = inflight;
    assign bus.clr_addr = clr_addr_q;
`else
    assign bus.clr_en   = 1'b0;
    assign bus.clr_addr = '0;
`endif

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_head;
endmodule

// File: tb/tb_obuf_drain.sv
module tb_obuf_drain;
    import obuf_drain_pkg::*;

    localparam int AW  = OBD_ARRAYWIDTH;
    localparam int DW  = OBD_DATASIZE;
    localparam int ADW = OBD_ADDR_W;
    localparam int RW  = AW * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    obuf_drain_if #(.ARRAYWIDTH(AW), .DATASIZE(DW), .ADDR_W(ADW)) bus ();

    obuf_drain #(.ARRAYWIDTH(AW), .DATASIZE(DW), .ADDR_W(ADW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Output buffer model: 1-cycle read latency, junk when not read, optional clear.
    logic [RW-1:0] mem [256];
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : '1;
        if (bus.clr_en) mem[bus.clr_addr] = '0;
    end

    task automatic fill_pattern();
        for (int r = 0; r < 256; r++)
            for (int i = 0; i < AW; i++)
                mem[r][i*DW +: DW] = DW'(r * 16 + i);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 256; r++)
            for (int i = 0; i < AW; i++)
                mem[r][i*DW +: DW] = DW'($urandom);
    endtask

    // Behavioural model: a drain is a list of rows snapshotted at start;
    // every valid must show the list head, done follows the cycle in which
    // the list is exhausted (or the first busy cycle for an empty drain).
    bit            chk_en = 0;
    bit            exp_busy = 0;
    bit            exp_done = 0;
    int            n_rows = 0;
    int            n_issued = 0;
    int            n_accepted = 0;
    int            hs_total = 0;
    int            clr_seen = 0;
    logic [RW-1:0] exp_q [$];
    bit            prev_stall = 0;
    logic [RW-1:0] prev_data = '0;
    bit            prev_rd = 0;
    logic [ADW-1:0] prev_rd_addr = '0;
    bit            prev_rst_low = 1;

    always @(negedge clk) begin
        bit hs;
        if (chk_en) begin
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("done", int'(bus.done), int'(exp_done));
            if (!exp_busy) begin
                chk("rd_en while idle", int'(bus.rd_en), 0);
                chk("out_valid while idle", int'(bus.out_valid), 0);
            end
            if (prev_rst_low) chk("rd_addr after reset", int'(bus.rd_addr), 0);
            if (bus.rd_en) begin
                chk("rd_addr order", int'(bus.rd_addr), n_issued);
                n_issued++;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra row: got valid row %0h, required no row", bus.out_data);
                end else begin
                    chk_row("row data", bus.out_data, exp_q[0]);
                end
            end
            if (prev_stall && !prev_rst_low) begin
                chk("valid held while stalled", int'(bus.out_valid), 1);
                chk_row("data held while stalled", bus.out_data, prev_data);
            end
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_accepted++;
                hs_total++;
            end
            tests++;
            if (n_issued - n_accepted > 2) begin
                fails++;
                $display("FAIL outstanding reads: got %0d, required at most 2", n_issued - n_accepted);
            end
`ifdef DRAIN_CLEAR_EN
            chk("clr_en follows rd_en", int'(bus.clr_en), int'(prev_rd && !prev_rst_low));
            if (bus.clr_en) chk("clr_addr", int'(bus.clr_addr), int'(prev_rd_addr));
`else
            chk("clr_en tied", int'(bus.clr_en), 0);
            chk("clr_addr tied", int'(bus.clr_addr), 0);
`endif
            if (bus.clr_en) clr_seen++;

            prev_stall   = bus.out_valid && !bus.out_ready;
            prev_data    = bus.out_data;
            prev_rd      = bus.rd_en;
            prev_rd_addr = bus.rd_addr;
            prev_rst_low = !rst;

            if (!rst) begin
                exp_busy = 0;
                exp_done = 0;
                exp_q.delete();
            end else if (exp_done) begin
                exp_busy = 0;
                exp_done = 0;
            end else if (!exp_busy) begin
                if (bus.start) begin
                    exp_busy   = 1;
                    n_rows     = int'(bus.num_rows);
                    n_issued   = 0;
                    n_accepted = 0;
                    exp_q.delete();
                    for (int r = 0; r < n_rows; r++) exp_q.push_back(mem[r]);
                end
            end else if (n_accepted == n_rows) begin
                exp_done = 1;
            end
        end
    end

    // Per-drain observations, offsets counted from the cycle start is high.
    int            first_valid, last_valid, done_off, valid_cnt, busy_cnt;
    int            rd_cnt, rd_hold, delivered, nz_cnt;
    logic [RW-1:0] first_data;

    task automatic run(input int n, input int ready_pct, input int hold,
                       input bit poke, input int rst_off, input int budget);
        int off;
        bit fin;
        bit busy_obs;
        int hs0;
        first_valid = -1; last_valid = -1; done_off = -1;
        valid_cnt = 0; busy_cnt = 0; rd_cnt = 0; rd_hold = 0; nz_cnt = 0;
        first_data = '0;
        hs0 = hs_total;
        @(posedge clk); #2;
        bus.start     = 1'b1;
        bus.num_rows  = ADW'(n);
        bus.out_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        off = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (first_valid < 0) begin
                    first_valid = off;
                    first_data  = bus.out_data;
                end
                valid_cnt++;
                last_valid = off;
                if (bus.out_data != '0) nz_cnt++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.rd_en) begin
                rd_cnt++;
                if (off < hold) rd_hold++;
            end
            busy_obs = bus.busy && !bus.done;
            if (bus.done) begin
                done_off = off;
                fin = 1;
            end
            if (rst_off >= 0 && off == rst_off + 1) begin
                chk("post-reset busy", int'(bus.busy), 0);
                chk("post-reset done", int'(bus.done), 0);
                chk("post-reset rd_en", int'(bus.rd_en), 0);
                chk("post-reset out_valid", int'(bus.out_valid), 0);
                chk("post-reset rd_addr", int'(bus.rd_addr), 0);
                chk("post-reset clr_en", int'(bus.clr_en), 0);
                fin = 1;
            end else if (!fin && off >= budget) begin
                tests++;
                fails++;
                $display("FAIL drain timeout: got no done within %0d cycles, required done", budget);
                fin = 1;
            end
            @(posedge clk); #2;
            bus.start = poke && busy_obs && ($urandom_range(0, 3) == 0);
            if (off == 0) bus.num_rows = ADW'($urandom);
            bus.out_ready = (off + 1 < hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
            if (rst_off >= 0) rst = (off != rst_off - 1);
            off++;
        end
        bus.start = 1'b0;
        rst = 1'b1;
        delivered = hs_total - hs0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] row0;
        int clr0;
        bus.start     = 1'b0;
        bus.num_rows  = '0;
        bus.out_ready = 1'b0;
        fill_pattern();
        repeat (2) @(posedge clk);
        #2 chk_en = 1;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset rd_en", int'(bus.rd_en), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset rd_addr", int'(bus.rd_addr), 0);
        chk("reset clr_en", int'(bus.clr_en), 0);

        // 1: four rows back to back
        row0 = '0;
        for (int i = 0; i < AW; i++) row0[i*DW +: DW] = DW'(i);
        run(4, 100, 0, 0, -1, 40);
        chk("t1 first valid offset", first_valid, 3);
        chk("t1 last valid offset", last_valid, 6);
        chk("t1 valid cycles", valid_cnt, 4);
        chk("t1 done offset", done_off, 7);
        chk("t1 busy cycles", busy_cnt, 7);
        chk("t1 reads", rd_cnt, 4);
        chk("t1 rows delivered", delivered, 4);
        chk_row("t1 first row", first_data, row0);

        // 2: empty drain
        run(0, 100, 0, 0, -1, 20);
        chk("t2 done offset", done_off, 2);
        chk("t2 busy cycles", busy_cnt, 2);
        chk("t2 reads", rd_cnt, 0);
        chk("t2 valid cycles", valid_cnt, 0);

        // 3: random back-pressure, spurious starts while busy
        fill_random();
        run(6, 50, 0, 1, -1, 200);
        chk("t3 rows delivered", delivered, 6);

        // 4: downstream stalled for 10 cycles
        run(5, 100, 11, 0, -1, 200);
        chk("t4 reads during stall", rd_hold, 2);
        chk("t4 rows delivered", delivered, 5);

        // 5: reset during third handshake, then a clean short drain
        fill_pattern();
        run(8, 100, 0, 0, 5, 100);
        fill_pattern();
        run(2, 100, 0, 0, -1, 40);
        chk("t5 rows delivered", delivered, 2);
        chk("t5 done offset", done_off, 5);
        chk_row("t5 first row", first_data, row0);

        // random drains
        for (int k = 0; k < 8; k++) begin
            int n;
            int pct;
            n   = $urandom_range(1, 20);
            pct = $urandom_range(20, 100);
            fill_random();
            run(n, pct, 0, 1, -1, 600);
            chk("random rows delivered", delivered, n);
        end

        // 6: buffer clearing
        fill_pattern();
        clr0 = clr_seen;
`ifdef DRAIN_CLEAR_EN
        run(3, 100, 0, 0, -1, 40);
        chk("t6 clear pulses", clr_seen - clr0, 3);
        run(3, 100, 0, 0, -1, 40);
        chk("t6 re-drain rows", delivered, 3);
        chk("t6 nonzero rows after clear", nz_cnt, 0);
`else
        run(3, 100, 0, 0, -1, 40);
        chk("t6 rows delivered", delivered, 3);
        chk("t6 clear pulses", clr_seen, 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
